tag_consensus_array: RTL and testbench
======================================

# tag_consensus_array

Parametrised, clocked successor to the 3-input tag C-element used in the ETROC2 readout. For each of NCH tag channels it combines NIN redundant copies of a tag bit into one resolved tag, with a selectable combine mode. It also detects per-channel disagreement, times out disagreements that never resolve, and keeps a saturating error count. It sits between the redundant tag sources and the readout frame builder.

## Interface
- NCH, 8: number of independent tag channels
- NIN, 3: redundant copies per channel (≥2)
- TMO_W, 8: width of the disagreement timeout counter and threshold
- ERR_W, 8: width of the error counter
- clk  in  1  readout clock; all state updates on the rising edge
- rstn  in  1  asynchronous, active-low reset
- mode  in  2  combine mode: 0 = C-element, 1 = majority, 2 = bypass copy 0, 3 = reserved (behaves as 0)
- timeout  in  TMO_W  disagreement timeout threshold in cycles; 0 disables the timeout
- clr_err  in  1  synchronous clear of err_cnt
- tag_in  in  NCH*NIN  channel c, copy k at bit c*NIN+k
- tag_out  out  NCH  resolved tag per channel
- disagree  out  NCH  copies of the channel are currently not all equal
- stuck  out  NCH  channel disagreement has reached the timeout
- err_cnt  out  ERR_W  saturating count of disagreement onsets

## Operation
- Reset: all internal registers and outputs are 0 (tag_out, disagree, stuck, err_cnt, the in_q sampling register, the per-channel timers, and mode_q).
- Stage 1: tag_in is registered into in_q on every edge.
- Stage 2: per channel c, evaluated from in_q[c]:
  - all1 = every copy is 1; all0 = every copy is 0; pop = popcount of the copies.
  - disagree[c] <= !(all1 | all0).
  - Mode 0/3, C-element: tag_out set on all1, cleared on all0, otherwise held.
  - Mode 1, majority: tag_out <= (pop > NIN/2). For even NIN, pop == NIN/2 holds the previous value.
  - Mode 2, bypass: tag_out <= copy 0.
- Timer, per channel, TMO_W bits:
  - Cleared when the channel agrees.
  - Incremented when the channel disagrees, saturating at all-ones.
  - stuck[c] <= (timeout != 0) & disagree condition & (timer + 1 >= timeout).
  - stuck clears on the first cycle the channel agrees.
- Stuck resolution, mode 0/3 only: while stuck[c] is 1, tag_out[c] follows the majority rule above instead of holding. Modes 1 and 2 ignore stuck for tag_out, but the stuck flag is still reported.
- Mode change: mode is registered into mode_q. In the cycle where mode != mode_q, all timers and stuck flags clear. tag_out evaluates with the new mode from the next edge.
- err_cnt:
  - Increments by 1 in each cycle where at least one channel goes from agree to disagree, i.e. the next disagree bit is 1 and the current disagree bit is 0.
  - Saturates at all-ones.
  - clr_err has priority over an increment in the same cycle.
- No handshake: the block is free-running. Inputs are assumed synchronous to clk.

## Timing
- Latency: tag_in captured at edge n appears on tag_out, disagree and stuck after edge n+1, i.e. 2 edges from input change to output.
- stuck asserts on the edge where the disagreement has persisted `timeout` consecutive evaluated cycles. With timeout = 1, stuck rises together with disagree.
- err_cnt updates on the same edge that disagree rises.
- rstn deassertion: the first valid outputs appear after 2 edges. Asserting rstn mid-disagreement clears the timer and stuck immediately, with no glitch on outputs after the reset release.
- Maximum combinational depth per channel: popcount of NIN plus a compare. The block is sized for NIN ≤ 7 at the readout clock.

## Test plan
- C-element hold, NIN=3, mode 0: tag_in channel 0 goes 000→111→101→001→000. tag_out[0] sequence after 2-edge latency: 0,1,1,1,0. disagree[0] is 1 only for the 101 and 001 cycles. err_cnt=1.
- Majority, mode 1: channel 2 gets 110 → tag_out[2]=1 and disagree[2]=1. Then 100 → tag_out[2]=0. err_cnt increments once because disagreement is continuous.
- Timeout, mode 0, timeout=4: channel 1 held at 011 starting with tag_out=0. stuck[1] rises after 4 disagree cycles, and on the same edge tag_out[1] becomes 1. Then 000 → stuck[1]=0 and tag_out[1]=0 on the next edge.
- Timeout disabled, timeout=0: channel 1 held at 011 for 300 cycles. stuck stays 0, the timer saturates at 255, and tag_out holds its prior value.
- err_cnt saturation and clear, ERR_W=8: toggle one channel agree/disagree 300 times. err_cnt reaches 255 and stays there. clr_err asserted together with a new onset → err_cnt=0 on the next edge.
- Reset and mode change: assert rstn=0 while stuck=1 → all outputs 0 asynchronously. After release, switch mode 0→2 while a channel disagrees → the timer and stuck clear, and tag_out tracks copy 0 from the following edge.

Source files
------------

// File: rtl/tag_consensus_array.sv
// tag_consensus_array
//   Resolves NIN redundant copies of each of NCH tag bits into one tag per
//   channel. Combine modes are C-element (hold on disagreement), majority,
//   and bypass of copy 0. Per-channel disagreement is flagged. A disagreement
//   that persists for `timeout` evaluated cycles raises `stuck`, and in
//   C-element mode this switches the channel to majority resolution. Onsets of
//   disagreement are counted in a saturating error counter.
//
// Ports
//   clk       in   readout clock, rising edge
//   rstn      in   asynchronous active-low reset
//   mode      in   [1:0] 0/3 C-element, 1 majority, 2 bypass copy 0
//   timeout   in   [TMO_W-1:0] disagreement threshold in cycles, 0 = off
//   clr_err   in   synchronous clear of err_cnt (wins over increment)
//   tag_in    in   [NCH*NIN-1:0] channel c copy k at bit c*NIN+k
//   tag_out   out  [NCH-1:0] resolved tag per channel
//   disagree  out  [NCH-1:0] copies of a channel not all equal
//   stuck     out  [NCH-1:0] disagreement has reached the timeout
//   err_cnt   out  [ERR_W-1:0] saturating count of disagreement onsets
module tag_consensus_array #(
  parameter int NCH   = 8,
  parameter int NIN   = 3,
  parameter int TMO_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           mode,
  input  logic [TMO_W-1:0]     timeout,
  input  logic                 clr_err,
  input  logic [NCH*NIN-1:0]   tag_in,
  output logic [NCH-1:0]       tag_out,
  output logic [NCH-1:0]       disagree,
  output logic [NCH-1:0]       stuck,
  output logic [ERR_W-1:0]     err_cnt
);

  // Majority vote; an exact tie (only possible for even NIN) keeps prev.
  function automatic logic majority(input logic [NIN-1:0] v, input logic prev);
    int p;
    p = 0;
    for (int k = 0; k < NIN; k++) p += int'(v[k]);
    if (2 * p > NIN)       majority = 1'b1;
    else if (2 * p == NIN) majority = prev;
    else                   majority = 1'b0;
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmr(input logic [TMO_W-1:0] v);
    sat_inc_tmr = (&v) ? v : v + TMO_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    sat_inc_err = (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [NCH*NIN-1:0]          in_q;
  logic [1:0]                  mode_q;
  logic [NCH-1:0]              tag_q, tag_d;
  logic [NCH-1:0]              dis_q, dis_d;
  logic [NCH-1:0]              stuck_q, stuck_d;
  logic [NCH-1:0][TMO_W-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]            err_q, err_d;
  logic                        mode_chg;
  logic                        onset;

  // Stage 1: sample the redundant copies and the mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_q   <= '0;
      mode_q <= 2'd0;
    end else begin
      in_q   <= tag_in;
      mode_q <= mode;
    end
  end

  // Stage 2: per-channel resolution, timers and error counting.
  always_comb begin
    mode_chg = (mode != mode_q);
    tag_d    = tag_q;
    dis_d    = '0;
    stuck_d  = '0;
    timer_d  = '0;
    for (int c = 0; c < NCH; c++) begin
      dis_d[c] = ~((&in_q[c*NIN +: NIN]) | ~(|in_q[c*NIN +: NIN]));

      // A mode change restarts timeout tracking from scratch.
      if (mode_chg || !dis_d[c]) timer_d[c] = '0;
      else                       timer_d[c] = sat_inc_tmr(timer_q[c]);

      // Extra bit keeps timer+1 from wrapping once the timer saturates.
      stuck_d[c] = !mode_chg && (timeout != '0) && dis_d[c] &&
                   (({1'b0, timer_q[c]} + (TMO_W+1)'(1)) >= {1'b0, timeout});

      // The mode takes effect one edge after it is sampled.
      case (mode_q)
        2'd1: tag_d[c] = majority(in_q[c*NIN +: NIN], tag_q[c]);
        2'd2: tag_d[c] = in_q[c*NIN];
        default: begin
          if (stuck_d[c])                    tag_d[c] = majority(in_q[c*NIN +: NIN], tag_q[c]);
          else if (&in_q[c*NIN +: NIN])      tag_d[c] = 1'b1;
          else if (~(|in_q[c*NIN +: NIN]))   tag_d[c] = 1'b0;
          else                               tag_d[c] = tag_q[c];
        end
      endcase
    end

    onset = |(dis_d & ~dis_q);
    if (clr_err)    err_d = '0;
    else if (onset) err_d = sat_inc_err(err_q);
    else            err_d = err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q   <= '0;
      dis_q   <= '0;
      stuck_q <= '0;
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      tag_q   <= tag_d;
      dis_q   <= dis_d;
      stuck_q <= stuck_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign tag_out  = tag_q;
  assign disagree = dis_q;
  assign stuck    = stuck_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_tag_consensus_array.sv
module tb_tag_consensus_array;
  localparam int NCH = 8, NIN = 3, TMO_W = 8, ERR_W = 8;

  logic                clk;
  logic                rstn;
  logic [1:0]          mode;
  logic [TMO_W-1:0]    timeout;
  logic                clr_err;
  logic [NCH*NIN-1:0]  tag_in;
  logic [NCH-1:0]      tag_out, disagree, stuck;
  logic [ERR_W-1:0]    err_cnt;

  int n_chk = 0;
  int n_bad = 0;

  tag_consensus_array #(.NCH(NCH), .NIN(NIN), .TMO_W(TMO_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .timeout(timeout), .clr_err(clr_err),
    .tag_in(tag_in), .tag_out(tag_out), .disagree(disagree), .stuck(stuck),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int c, input logic [NIN-1:0] v);
    tag_in[c*NIN +: NIN] = v;
  endtask

  initial begin
    rstn = 1'b0; mode = 2'd0; timeout = '0; clr_err = 1'b0; tag_in = '0;
    #12;
    check("rst_tag", 32'(tag_out), 32'h0);
    check("rst_dis", 32'(disagree), 32'h0);
    check("rst_stuck", 32'(stuck), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    rstn = 1'b1;
    step(3);

    // C-element hold on channel 0
    set_ch(0, 3'b000); step(2);
    check("c_000_tag", 32'(tag_out), 32'h00);
    set_ch(0, 3'b111); step(2);
    check("c_111_tag", 32'(tag_out), 32'h01);
    check("c_111_dis", 32'(disagree), 32'h00);
    set_ch(0, 3'b101); step(2);
    check("c_101_tag", 32'(tag_out), 32'h01);
    check("c_101_dis", 32'(disagree), 32'h01);
    check("c_101_err", 32'(err_cnt), 32'd1);
    set_ch(0, 3'b001); step(2);
    check("c_001_tag", 32'(tag_out), 32'h01);
    check("c_001_dis", 32'(disagree), 32'h01);
    set_ch(0, 3'b000); step(2);
    check("c_000b_tag", 32'(tag_out), 32'h00);
    check("c_000b_dis", 32'(disagree), 32'h00);
    check("c_err", 32'(err_cnt), 32'd1);

    // Majority on channel 2
    clr_err = 1'b1; mode = 2'd1; step(1);
    clr_err = 1'b0;
    check("clr_err", 32'(err_cnt), 32'd0);
    step(1);
    set_ch(2, 3'b110); step(2);
    check("maj_110_tag", 32'(tag_out), 32'h04);
    check("maj_110_dis", 32'(disagree), 32'h04);
    set_ch(2, 3'b100); step(2);
    check("maj_100_tag", 32'(tag_out), 32'h00);
    check("maj_100_dis", 32'(disagree), 32'h04);
    check("maj_err", 32'(err_cnt), 32'd1);
    set_ch(2, 3'b000); mode = 2'd0; step(3);

    // Timeout = 4 on channel 1, C-element mode
    timeout = 8'd4;
    set_ch(1, 3'b011); step(4);
    check("tmo4_pre_stuck", 32'(stuck), 32'h00);
    check("tmo4_pre_tag", 32'(tag_out), 32'h00);
    check("tmo4_pre_dis", 32'(disagree), 32'h02);
    step(1);
    check("tmo4_stuck", 32'(stuck), 32'h02);
    check("tmo4_tag", 32'(tag_out), 32'h02);
    check("tmo4_err", 32'(err_cnt), 32'd2);
    set_ch(1, 3'b000); step(2);
    check("tmo4_rel_stuck", 32'(stuck), 32'h00);
    check("tmo4_rel_tag", 32'(tag_out), 32'h00);

    // Timeout disabled: timer saturates, tag holds
    timeout = 8'd0;
    set_ch(1, 3'b011); step(300);
    check("tmo0_stuck", 32'(stuck), 32'h00);
    check("tmo0_tag", 32'(tag_out), 32'h00);
    check("tmo0_timer", 32'(dut.timer_q[1]), 32'd255);
    timeout = 8'd4; step(1);
    check("tmo_sat_stuck", 32'(stuck), 32'h02);
    check("tmo_sat_tag", 32'(tag_out), 32'h02);
    set_ch(1, 3'b000); timeout = 8'd0; step(2);
    check("tmo_sat_rel_tag", 32'(tag_out), 32'h00);

    // err_cnt counting, saturation and clear priority
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      set_ch(3, 3'b001); step(1);
      set_ch(3, 3'b000); step(1);
    end
    step(2);
    check("err_100", 32'(err_cnt), 32'd100);
    for (int i = 0; i < 200; i++) begin
      set_ch(3, 3'b001); step(1);
      set_ch(3, 3'b000); step(1);
    end
    step(2);
    check("err_sat", 32'(err_cnt), 32'd255);
    set_ch(3, 3'b001); step(1);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("err_clr_prio", 32'(err_cnt), 32'd0);
    check("err_clr_dis", 32'(disagree), 32'h08);
    set_ch(3, 3'b000); step(2);

    // Async reset while stuck, then mode change 0 -> 2
    timeout = 8'd2;
    set_ch(1, 3'b011); step(3);
    check("pre_rst_stuck", 32'(stuck), 32'h02);
    #2 rstn = 1'b0;
    #1;
    check("arst_tag", 32'(tag_out), 32'h00);
    check("arst_stuck", 32'(stuck), 32'h00);
    check("arst_dis", 32'(disagree), 32'h00);
    check("arst_timer", 32'(dut.timer_q[1]), 32'd0);
    step(2);
    @(negedge clk); rstn = 1'b1;
    step(1);
    check("post_rst1_dis", 32'(disagree), 32'h00);
    check("post_rst1_stuck", 32'(stuck), 32'h00);
    step(1);
    check("post_rst2_dis", 32'(disagree), 32'h02);
    check("post_rst2_stuck", 32'(stuck), 32'h00);
    check("post_rst2_err", 32'(err_cnt), 32'd1);
    mode = 2'd2; step(1);
    check("mchg_stuck", 32'(stuck), 32'h00);
    check("mchg_tag", 32'(tag_out), 32'h00);
    check("mchg_timer", 32'(dut.timer_q[1]), 32'd0);
    step(1);
    check("byp_tag", 32'(tag_out), 32'h02);
    set_ch(1, 3'b110); step(2);
    check("byp_110_tag", 32'(tag_out), 32'h00);
    check("byp_110_stuck", 32'(stuck), 32'h02);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
